// File: rtl/i2c_target.sv
// I2C target: oversamples SCL/SDA, detects START/STOP, matches a 7-bit address and
// moves write/read bytes through a one-cycle rx_valid / tx_req byte handshake.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw_dir
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    logic [SYNC_LEN-1:0] scl_sync_reg;
    logic [SYNC_LEN-1:0] sda_sync_reg;
    logic                scl_prev_reg;
    logic                sda_prev_reg;

    state_t     state_reg,    state_next;
    logic [2:0] bit_cnt_reg,  bit_cnt_next;
    logic       full_reg,     full_next;
    logic [7:0] shift_reg,    shift_next;
    logic       sda_oe_reg,   sda_oe_next;
    logic [7:0] rx_data_reg,  rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_req_reg,   tx_req_next;
    logic       busy_reg,     busy_next;
    logic       rw_dir_reg,   rw_dir_next;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_oe;

    // Synchronizers preset to the idle bus level so reset release never looks like START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_LEN-2:0], scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_LEN-2:0], sda};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_LEN-1];
    assign sda_s     = sda_sync_reg[SYNC_LEN-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    // Bus conditions drop the pull-down combinationally rather than a cycle later.
    assign sda_oe = sda_oe_reg & ~start_det & ~stop_det;
    assign sda    = sda_oe ? 1'b0 : 1'bz;

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_req   = tx_req_reg;
    assign busy     = busy_reg;
    assign rw_dir   = rw_dir_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            full_reg     <= 1'b0;
            shift_reg    <= 8'd0;
            sda_oe_reg   <= 1'b0;
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            rw_dir_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            full_reg     <= full_next;
            shift_reg    <= shift_next;
            sda_oe_reg   <= sda_oe_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            tx_req_reg   <= tx_req_next;
            busy_reg     <= busy_next;
            rw_dir_reg   <= rw_dir_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        full_next     = full_reg;
        shift_next    = shift_reg;
        sda_oe_next   = sda_oe_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;
        busy_next     = busy_reg;
        rw_dir_next   = rw_dir_reg;

        // The read byte is captured while tx_req is high; no SCL edge can coincide with it.
        if (tx_req_reg) begin
            shift_next = tx_data;
        end

        if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 3'd0;
            full_next    = 1'b0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = 3'd0;
            full_next    = 1'b0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE, IGNORE: begin
                    sda_oe_next = 1'b0;
                end
                ADDR, WR_DATA: begin
                    // full_reg marks that 8 bits are in; further rises are not shifted.
                    if (scl_rise && !full_reg) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            full_next = 1'b1;
                        end
                    end else if (scl_fall && full_reg) begin
                        full_next    = 1'b0;
                        bit_cnt_next = 3'd0;
                        if (state_reg == WR_DATA) begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                            sda_oe_next   = 1'b1;
                            state_next    = WR_ACK;
                        end else if (shift_reg[7:1] == DEV_ADDR) begin
                            sda_oe_next = 1'b1;
                            rw_dir_next = shift_reg[0];
                            busy_next   = 1'b1;
                            tx_req_next = shift_reg[0];
                            state_next  = ADDR_ACK;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 3'd0;
                        if (rw_dir_reg) begin
                            sda_oe_next = ~shift_reg[7];
                            state_next  = RD_DATA;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = WR_DATA;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next = 1'b0;
                        state_next  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // Bit 7 is already on the bus; each fall presents the next bit.
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_next = 3'd0;
                            sda_oe_next  = 1'b0;
                            state_next   = RD_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_oe_next  = ~shift_reg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_next = IGNORE;
                        end else begin
                            tx_req_next = 1'b1;
                        end
                    end else if (scl_fall) begin
                        bit_cnt_next = 3'd0;
                        sda_oe_next  = ~shift_reg[7];
                        state_next   = RD_DATA;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

endmodule
